vga_trail_gen: RTL and testbench
================================

# vga_trail_gen

Per-frame generator of the player trail particle buffer consumed by `vga_screen_pic` (`trail_x`, `trail_y`, `trail_life`). On each frame tick it ages every particle sequentially, one slot per cycle, then spawns a new particle behind the player. All updates complete inside vertical blanking, so the renderer sees stable arrays during active video.

## Interface

**Parameters**
- `TRAIL_LEN`, 41: number of particle slots; must match the renderer array depth.
- `PLAYER_X`, 160: player left edge, in pixels.
- `PLAYER_SIZE`, 40: player sprite size, in pixels.
- `MAX_LIFE`, 10: life given to a new particle; must be ≤ 15.
- `X_STEP`, 4: leftward drift per frame, in pixels.
- `SPAWN_PERIOD`, 2: spawn one particle every N eligible frames; must be ≥ 1.

**Ports**
- `clk` in 1: system clock. One clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse at the start of vertical blanking.
- `gamemode` in 2: 00 init, 01 running, 10 paused, 11 ended.
- `player_y` in 9: player top edge, in pixels.
- `trail_x` out [TRAIL_LEN-1:0][9:0]: particle centre x, registered.
- `trail_y` out [TRAIL_LEN-1:0][8:0]: particle centre y, registered.
- `trail_life` out [TRAIL_LEN-1:0][3:0]: particle life; 0 means dead. Registered.
- `busy` out 1: high while an update is in progress.
- `done` out 1: one-cycle pulse when an update completes.
- `overrun` out 1: sticky flag; set when a `frame_tick` arrives while `busy` is high.

## Operation

**Reset** (`rst_n` = 0): all of the following clear to 0, and the FSM goes to IDLE.
- Outputs: every `trail_x`, `trail_y`, `trail_life` entry, `busy`, `done`, `overrun`.
- Internal: write pointer `wptr`, spawn counter `scnt`, index `idx`.

**Clear** (`gamemode` == 00, sampled every cycle): highest priority after reset.
- All `trail_life` entries go to 0; `wptr`, `scnt`, `overrun` go to 0.
- FSM goes to IDLE; any update in progress is aborted.
- `trail_x` and `trail_y` are left unchanged.

**FSM**
- **IDLE**
  - `frame_tick` with `gamemode` 01 or 11: latch `mode_l` ← `gamemode` and `py_l` ← `player_y`; set `idx` ← 0; go to AGE.
  - `frame_tick` with `gamemode` 10: ignored. All state is frozen.
- **AGE**: one slot `idx` per cycle.
  - If `life[idx]` == 0: no change.
  - Else if `trail_x[idx]` < `X_STEP`: `life` ← 0.
  - Else: `life` ← `life` − 1 and `trail_x` ← `trail_x` − `X_STEP`.
  - `trail_y` is never modified by aging.
  - After `idx` == `TRAIL_LEN`−1, go to SPAWN.
- **SPAWN**: one cycle.
  - Spawns only if `mode_l` == 01 and `scnt` == `SPAWN_PERIOD`−1. Then slot `wptr` gets:
    - `trail_x` ← `PLAYER_X`−1
    - `trail_y` ← (`py_l` + `PLAYER_SIZE`/2), truncated to 9 bits
    - `trail_life` ← `MAX_LIFE`
  - A spawn overwrites the slot regardless of its current life.
  - On spawn, `wptr` ← `wptr`+1, wrapping from `TRAIL_LEN`−1 to 0.
  - `scnt` advances only when `mode_l` == 01: if it equals `SPAWN_PERIOD`−1 it resets to 0, otherwise it increments.
  - Go to DONE.
- **DONE**: pulse `done` for one cycle, then go to IDLE.

**Other rules**
- A `frame_tick` while `busy` is high is ignored and sets `overrun`.
- The ended mode (11) keeps aging the trail so it fades out, but never spawns.
- `gamemode` changing between 01, 10 and 11 during an update does not affect that update, because `mode_l` is latched. Only 00 aborts.

## Timing

- `frame_tick` at cycle T:
  - `busy` is high from T+1 through T+`TRAIL_LEN`+1.
  - Slot i is aged at the edge ending cycle T+1+i.
  - The spawn write lands at the edge ending cycle T+`TRAIL_LEN`+1.
  - `done` is high at T+`TRAIL_LEN`+2; `busy` is low in that cycle.
- With default parameters the update takes 43 cycles, well inside the VGA vertical blanking interval.
- Outputs change only while `busy` or `done` is high, or on clear/reset.
- `frame_tick` in the same cycle as `gamemode` == 00: clear wins and no update starts.

## Test plan

1. **Reset**: assert `rst_n` low mid-update → all lives 0, `busy` = 0, `done` = 0 immediately, with no clock edge required.
2. **Spawn**: `gamemode` = 01, `player_y` = 200, two ticks.
   - Tick 1: no spawn.
   - Tick 2: slot 0 = (x 159, y 220, life 10), `done` at T+43.
3. **Aging and death**:
   - Slot with x = 159, life = 10 → after 1 tick: x 155, life 9.
   - Slot with x = 3, life = 5 → after 1 tick: life 0.
4. **Wraparound**: 84 ticks in mode 01 → 42 spawns, `wptr` wraps, slot 0 is overwritten by spawn 42 (life 10), and the remaining slots hold older particles.
5. **Pause and end**:
   - Mode 10 with ticks → all arrays are bit-identical.
   - Mode 11: lives decrement each tick with no new spawns; all lives reach 0 within 10 ticks.
6. **Overrun and clear**:
   - `frame_tick` at T+5 of an update → `overrun` = 1 and the update finishes normally.
   - `gamemode` = 00 at T+20 → lives 0, `busy` = 0 the next cycle, `overrun` cleared.

Source files
------------

// File: rtl/vga_trail_gen.sv
// vga_trail_gen
// Builds the player trail particle buffer read by the renderer. Each frame
// tick starts an update. The update ages every slot, one per cycle, and then
// may spawn one new particle behind the player. The whole update fits inside
// vertical blanking, so the arrays stay stable during active video.
//
// Ports:
//   clk, rst_n       system clock and asynchronous active-low reset
//   frame_tick       one-cycle pulse at the start of vertical blanking
//   gamemode         00 init (clears the trail), 01 running, 10 paused, 11 ended
//   player_y         player top edge, in pixels
//   trail_x/y/life   registered particle arrays; a life of 0 means the slot is dead
//   busy             high while an update is running
//   done             one-cycle pulse after an update completes
//   overrun          sticky flag; set by a frame_tick that arrives while busy
module vga_trail_gen #(
    parameter int TRAIL_LEN    = 41,
    parameter int PLAYER_X     = 160,
    parameter int PLAYER_SIZE  = 40,
    parameter int MAX_LIFE     = 10,
    parameter int X_STEP       = 4,
    parameter int SPAWN_PERIOD = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       frame_tick,
    input  logic [1:0]                 gamemode,
    input  logic [8:0]                 player_y,
    output logic [TRAIL_LEN-1:0][9:0]  trail_x,
    output logic [TRAIL_LEN-1:0][8:0]  trail_y,
    output logic [TRAIL_LEN-1:0][3:0]  trail_life,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun
);

    localparam int IDX_W  = (TRAIL_LEN > 1) ? $clog2(TRAIL_LEN) : 1;
    localparam int SCNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(TRAIL_LEN - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SPAWN_PERIOD - 1);
    localparam logic [9:0]        STEP_X    = 10'(X_STEP);
    localparam logic [9:0]        SPAWN_X   = 10'(PLAYER_X - 1);
    localparam logic [8:0]        Y_OFF     = 9'(PLAYER_SIZE / 2);
    localparam logic [3:0]        NEW_LIFE  = 4'(MAX_LIFE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AGE,
        ST_SPAWN,
        ST_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [IDX_W-1:0]            wptr_q, wptr_d;
    logic [SCNT_W-1:0]           scnt_q, scnt_d;
    logic [1:0]                  mode_l_q, mode_l_d;
    logic [8:0]                  py_l_q, py_l_d;
    logic [TRAIL_LEN-1:0][9:0]   x_q, x_d;
    logic [TRAIL_LEN-1:0][8:0]   y_q, y_d;
    logic [TRAIL_LEN-1:0][3:0]   life_q, life_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        overrun_q, overrun_d;

    assign trail_x    = x_q;
    assign trail_y    = y_q;
    assign trail_life = life_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overrun    = overrun_q;

    // State and data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            wptr_q    <= '0;
            scnt_q    <= '0;
            mode_l_q  <= 2'b00;
            py_l_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            life_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wptr_q    <= wptr_d;
            scnt_q    <= scnt_d;
            mode_l_q  <= mode_l_d;
            py_l_q    <= py_l_d;
            x_q       <= x_d;
            y_q       <= y_d;
            life_q    <= life_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state logic. Init mode overrides everything else: it kills every
    // particle and aborts an update. The particle positions are kept because
    // a dead slot is never drawn. busy and done are decoded from the next
    // state, so they line up with the state cycles they describe.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wptr_d    = wptr_q;
        scnt_d    = scnt_q;
        mode_l_d  = mode_l_q;
        py_l_d    = py_l_q;
        x_d       = x_q;
        y_d       = y_q;
        life_d    = life_q;
        overrun_d = overrun_q;

        if (gamemode == 2'b00) begin
            state_d   = ST_IDLE;
            idx_d     = '0;
            wptr_d    = '0;
            scnt_d    = '0;
            overrun_d = 1'b0;
            life_d    = '0;
        end else begin
            if (frame_tick && busy_q) begin
                overrun_d = 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    // A tick in paused mode is dropped, so the buffer stays frozen.
                    if (frame_tick && (gamemode != 2'b10)) begin
                        mode_l_d = gamemode;
                        py_l_d   = player_y;
                        idx_d    = '0;
                        state_d  = ST_AGE;
                    end
                end
                ST_AGE: begin
                    // A particle that would drift past the left edge dies in place.
                    if (life_q[idx_q] != 4'd0) begin
                        if (x_q[idx_q] < STEP_X) begin
                            life_d[idx_q] = 4'd0;
                        end else begin
                            life_d[idx_q] = life_q[idx_q] - 4'd1;
                            x_d[idx_q]    = x_q[idx_q] - STEP_X;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_SPAWN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                ST_SPAWN: begin
                    // Ended mode (11) keeps aging but never spawns and never
                    // advances the spawn counter.
                    if (mode_l_q == 2'b01) begin
                        if (scnt_q == SCNT_LAST) begin
                            scnt_d         = '0;
                            x_d[wptr_q]    = SPAWN_X;
                            y_d[wptr_q]    = py_l_q + Y_OFF;
                            life_d[wptr_q] = NEW_LIFE;
                            wptr_d         = (wptr_q == LAST_IDX) ? '0 : wptr_q + 1'b1;
                        end else begin
                            scnt_d = scnt_q + 1'b1;
                        end
                    end
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_AGE) || (state_d == ST_SPAWN);
        done_d = (state_d == ST_DONE);
    end

endmodule

// File: tb/tb_vga_trail_gen.sv
// tb_vga_trail_gen
// Self-checking bench for vga_trail_gen. A behavioural model holds the
// particles as integer arrays and applies each frame update as a single step.
// Randomized frames, modes, overrun ticks and mid-update mode changes are
// compared against that model. A second, small instance with different
// parameters covers the rule that kills a particle at the left edge.
module tb_vga_trail_gen;

    localparam int L     = 41;
    localparam int PX    = 160;
    localparam int PS    = 40;
    localparam int MLIFE = 10;
    localparam int XS    = 4;
    localparam int SP    = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                frame_tick;
    logic [1:0]          gamemode;
    logic [8:0]          player_y;
    logic [L-1:0][9:0]   trail_x;
    logic [L-1:0][8:0]   trail_y;
    logic [L-1:0][3:0]   trail_life;
    logic                busy;
    logic                done;
    logic                overrun;

    logic [3:0][9:0]     t2_x;
    logic [3:0][8:0]     t2_y;
    logic [3:0][3:0]     t2_life;
    logic                t2_busy;
    logic                t2_done;
    logic                t2_ovr;

    int checks = 0;
    int errors = 0;

    int mx[L];
    int my[L];
    int ml[L];
    int mwptr;
    int mscnt;
    bit movr;

    vga_trail_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .gamemode   (gamemode),
        .player_y   (player_y),
        .trail_x    (trail_x),
        .trail_y    (trail_y),
        .trail_life (trail_life),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    vga_trail_gen #(
        .TRAIL_LEN    (4),
        .PLAYER_X     (8),
        .PLAYER_SIZE  (40),
        .MAX_LIFE     (15),
        .X_STEP       (4),
        .SPAWN_PERIOD (1)
    ) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .gamemode   (gamemode),
        .player_y   (player_y),
        .trail_x    (t2_x),
        .trail_y    (t2_y),
        .trail_life (t2_life),
        .busy       (t2_busy),
        .done       (t2_done),
        .overrun    (t2_ovr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < L; i++) begin
            mx[i] = 0;
            my[i] = 0;
            ml[i] = 0;
        end
        mwptr = 0;
        mscnt = 0;
        movr  = 1'b0;
    endfunction

    function automatic void modelClear();
        for (int i = 0; i < L; i++) ml[i] = 0;
        mwptr = 0;
        mscnt = 0;
        movr  = 1'b0;
    endfunction

    function automatic void modelAge(input int i);
        if (ml[i] != 0) begin
            if (mx[i] < XS) begin
                ml[i] = 0;
            end else begin
                ml[i] = ml[i] - 1;
                mx[i] = mx[i] - XS;
            end
        end
    endfunction

    function automatic void modelFrame(input int mode, input int py);
        for (int i = 0; i < L; i++) modelAge(i);
        if (mode == 1) begin
            if (mscnt == SP - 1) begin
                mx[mwptr] = PX - 1;
                my[mwptr] = (py + PS / 2) % 512;
                ml[mwptr] = MLIFE;
                mwptr     = (mwptr + 1) % L;
            end
            mscnt = (mscnt + 1) % SP;
        end
    endfunction

    function automatic logic [511:0] expX();
        logic [511:0] r = '0;
        for (int i = 0; i < L; i++) r[i*10 +: 10] = 10'(mx[i]);
        return r;
    endfunction

    function automatic logic [511:0] expY();
        logic [511:0] r = '0;
        for (int i = 0; i < L; i++) r[i*9 +: 9] = 9'(my[i]);
        return r;
    endfunction

    function automatic logic [511:0] expLife();
        logic [511:0] r = '0;
        for (int i = 0; i < L; i++) r[i*4 +: 4] = 4'(ml[i]);
        return r;
    endfunction

    task automatic checkArrays(input string tag);
        checkOutput({tag, "_x"}, 512'(trail_x), expX());
        checkOutput({tag, "_y"}, 512'(trail_y), expY());
        checkOutput({tag, "_life"}, 512'(trail_life), expLife());
        checkOutput({tag, "_overrun"}, 512'(overrun), 512'(movr));
    endtask

    // One frame: tick with gm, optionally inject a second tick at cycle T+ovr_at
    // and change gamemode to gm2 at cycle T+chg_at (0 means never).
    task automatic applyStimulus(input logic [1:0] gm, input logic [8:0] py,
                                 input int ovr_at, input int chg_at, input logic [1:0] gm2);
        int k;
        @(negedge clk);
        checkOutput("done_pulse", 512'(done), 512'(0));
        frame_tick = 1'b1;
        gamemode   = gm;
        player_y   = py;
        if (gm == 2'b00) begin
            @(negedge clk);
            frame_tick = 1'b0;
            modelClear();
            checkOutput("clr_busy", 512'(busy), 512'(0));
            checkArrays("clr");
        end else if (gm == 2'b10) begin
            @(negedge clk);
            frame_tick = 1'b0;
            checkOutput("pause_busy", 512'(busy), 512'(0));
            @(negedge clk);
            checkOutput("pause_busy2", 512'(busy), 512'(0));
            checkArrays("pause");
        end else begin
            modelFrame(int'(gm), int'(py));
            k = 0;
            while (k < 60) begin
                @(negedge clk);
                k++;
                frame_tick = 1'b0;
                if (done) break;
                if (k == 1) checkOutput("busy_first", 512'(busy), 512'(1));
                if (k == L + 1) checkOutput("busy_last", 512'(busy), 512'(1));
                if (k == ovr_at) begin
                    frame_tick = 1'b1;
                    movr       = 1'b1;
                end
                if (k == chg_at) gamemode = gm2;
            end
            checkOutput("latency", 512'(k), 512'(L + 2));
            checkOutput("done_busy", 512'(busy), 512'(0));
            checkArrays("frame");
        end
    endtask

    task automatic clearMidUpdate(input logic [8:0] py);
        @(negedge clk);
        frame_tick = 1'b1;
        gamemode   = 2'b01;
        player_y   = py;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (19) @(negedge clk);
        gamemode = 2'b00;
        for (int i = 0; i < 19; i++) modelAge(i);
        modelClear();
        @(negedge clk);
        checkOutput("clrmid_busy", 512'(busy), 512'(0));
        checkOutput("clrmid_done", 512'(done), 512'(0));
        checkArrays("clrmid");
    endtask

    task automatic resetMidUpdate();
        @(negedge clk);
        frame_tick = 1'b1;
        gamemode   = 2'b01;
        player_y   = 9'd77;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("rstmid_busy", 512'(busy), 512'(0));
        checkOutput("rstmid_done", 512'(done), 512'(0));
        checkArrays("rstmid");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] gm;
        logic [1:0] gm2;
        int         r;
        int         ovr;
        int         chg;

        rst_n      = 1'b0;
        frame_tick = 1'b0;
        gamemode   = 2'b00;
        player_y   = '0;
        modelReset();
        repeat (3) @(negedge clk);
        checkArrays("reset");
        checkOutput("reset_busy", 512'(busy), 512'(0));
        checkOutput("reset_done", 512'(done), 512'(0));
        rst_n = 1'b1;

        // First tick only advances the spawn counter; the second spawns in slot 0.
        applyStimulus(2'b01, 9'd200, 0, 0, 2'b01);
        checkOutput("t1_life0", 512'(trail_life[0]), 512'(0));
        applyStimulus(2'b01, 9'd200, 0, 0, 2'b01);
        checkOutput("t2_x0", 512'(trail_x[0]), 512'(159));
        checkOutput("t2_y0", 512'(trail_y[0]), 512'(220));
        checkOutput("t2_life0", 512'(trail_life[0]), 512'(10));
        applyStimulus(2'b01, 9'd200, 0, 0, 2'b01);
        checkOutput("t3_x0", 512'(trail_x[0]), 512'(155));
        checkOutput("t3_life0", 512'(trail_life[0]), 512'(9));
        // Small instance: slot 0 went 7 -> 3 -> dead at the left edge.
        checkOutput("edge_life", 512'(t2_life), 512'(16'h0FE0));
        checkOutput("edge_x", 512'(t2_x), 512'({10'd0, 10'd7, 10'd3, 10'd3}));
        checkOutput("edge_y", 512'(t2_y), 512'({9'd0, 9'd220, 9'd220, 9'd220}));

        // Wraparound: 84 ticks give 42 spawns, so the 42nd lands back in slot 0.
        applyStimulus(2'b00, 9'd0, 0, 0, 2'b00);
        repeat (84) applyStimulus(2'b01, 9'($urandom_range(0, 511)), 0, 0, 2'b01);
        checkOutput("wrap_life0", 512'(trail_life[0]), 512'(10));

        repeat (3) applyStimulus(2'b10, 9'($urandom_range(0, 511)), 0, 0, 2'b10);

        repeat (10) applyStimulus(2'b11, 9'($urandom_range(0, 511)), 0, 0, 2'b11);
        checkOutput("fade_all", 512'(trail_life), 512'(0));

        applyStimulus(2'b01, 9'd100, 5, 0, 2'b01);
        checkOutput("ovr_flag", 512'(overrun), 512'(1));

        repeat (4) applyStimulus(2'b01, 9'($urandom_range(0, 511)), 0, 0, 2'b01);
        clearMidUpdate(9'd50);

        for (int n = 0; n < 30; n++) begin
            r   = $urandom_range(0, 9);
            gm  = (r < 6) ? 2'b01 : (r < 7) ? 2'b11 : (r < 8) ? 2'b10 : 2'b00;
            ovr = ($urandom_range(0, 3) == 0) ? $urandom_range(1, L + 1) : 0;
            chg = ($urandom_range(0, 2) == 0) ? $urandom_range(1, L + 1) : 0;
            gm2 = 2'($urandom_range(1, 3));
            applyStimulus(gm, 9'($urandom_range(0, 511)), ovr, chg, gm2);
        end

        resetMidUpdate();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
